// File: rtl/seq_multiplier_if.sv
// Handshake bundle for seq_multiplier: operand side (in_*) and result side (out_*).
// The multiplier uses the slave modport; the operand source / result consumer
// uses the master modport.
interface seq_multiplier_if #(
  parameter int data_width = 4
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [data_width-1:0]     A;
  logic [data_width-1:0]     B;
  logic                      signed_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*data_width-1:0]   product;

  modport master (
    output in_valid,
    input  in_ready,
    output A,
    output B,
    output signed_mode,
    input  out_valid,
    output out_ready,
    input  product
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  A,
    input  B,
    input  signed_mode,
    output out_valid,
    input  out_ready,
    output product
  );

endinterface

// File: rtl/seq_multiplier.sv
// Iterative N x N shift-add multiplier with per-operation signed/unsigned mode.
// Operands are reduced to unsigned magnitudes on accept, multiplied one bit of
// B per cycle, and the sign is reapplied in a single FIX cycle.
//
// Optional feature: define MULT_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier bits are all zero (same products, shorter latency).
//
// state | meaning
// IDLE  | ready for operands, in_ready=1
// CALC  | one shift-add step per cycle over the bits of |B|
// FIX   | apply sign to the accumulator into the product register
// DONE  | product valid, waiting for out_ready
module seq_multiplier #(
  parameter int data_width = 4
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);

  localparam int step_width = (data_width > 2) ? $clog2(data_width) : 1;
  localparam logic [step_width-1:0] last_step = step_width'(data_width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [data_width-1:0]   amag, bmag;
  logic [2*data_width-1:0] acc;
  logic [2*data_width-1:0] product_reg;
  logic [step_width-1:0]   step;
  logic                    neg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;

  logic                    load, calc, fix, calc_last;
  logic [data_width-1:0]   mag_a, mag_b;
  logic                    neg_in;
  logic [2*data_width-1:0] wide_a;

  // Operand magnitudes and result sign; zero operands never yield a negative result.
  always_comb begin
    mag_a  = (bus.signed_mode && bus.A[data_width-1]) ? ('0 - bus.A) : bus.A;
    mag_b  = (bus.signed_mode && bus.B[data_width-1]) ? ('0 - bus.B) : bus.B;
    neg_in = bus.signed_mode && (bus.A[data_width-1] ^ bus.B[data_width-1])
             && (bus.A != '0) && (bus.B != '0);
    wide_a = {{data_width{1'b0}}, amag};
  end

  // Last CALC step: fixed count, or (optionally) once no multiplier bits remain.
  always_comb begin
    calc_last = (step == last_step);
`ifdef MULT_EARLY_TERM_EN
    if (bmag[data_width-1:1] == '0) begin
      calc_last = 1'b1;
    end
`else
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    calc       = 1'b0;
    fix        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        calc = 1'b1;
        if (calc_last) begin
          next_state = FIX;
        end
      end
      FIX: begin
        fix        = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latch, shift-add accumulation and signed product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      amag        <= '0;
      bmag        <= '0;
      acc         <= '0;
      step        <= '0;
      neg         <= 1'b0;
      product_reg <= '0;
    end else begin
      if (load) begin
        amag <= mag_a;
        bmag <= mag_b;
        neg  <= neg_in;
        acc  <= '0;
        step <= '0;
      end
      if (calc) begin
        if (bmag[0]) begin
          acc <= acc + (wide_a << step);
        end
        bmag <= bmag >> 1;
        step <= step + step_width'(1);
      end
      if (fix) begin
        product_reg <= neg ? ('0 - acc) : acc;
      end
    end
  end

  // Handshake outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      in_ready_reg  <= (next_state == IDLE);
      out_valid_reg <= (next_state == DONE);
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.product   = product_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (N=4): reset state, signed/unsigned vectors,
// backpressure, reset mid-calculation, early termination and a full operand sweep.
module tb_seq_multiplier;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_multiplier_if #(.data_width(4)) bus ();

  seq_multiplier #(.data_width(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected latency from accept edge to out_valid for a given B and mode.
  function automatic int lat_for(input logic [3:0] b, input logic sm);
`ifdef MULT_EARLY_TERM_EN
    logic [3:0] m;
    int bl;
    m  = (sm && b[3]) ? (4'd0 - b) : b;
    bl = 0;
    for (int i = 0; i < 4; i++) if (m[i]) bl = i + 1;
    if (bl < 1) bl = 1;
    return bl + 1;
`else
    return 5;
`endif
  endfunction

  // Issue one operation from IDLE and wait for out_valid; leaves DUT in DONE.
  task automatic issue_and_wait(input logic [3:0] a, input logic [3:0] b, input logic sm,
                                input logic [7:0] exp_p, input int exp_lat, input string tag);
    int cyc;
    chk({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
    bus.in_valid    = 1'b1;
    bus.A           = a;
    bus.B           = b;
    bus.signed_mode = sm;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_out_valid"}, 16'(bus.out_valid), 16'd1);
    chk({tag, "_latency"}, 16'(cyc), 16'(exp_lat));
    chk({tag, "_product"}, 16'(bus.product), 16'(exp_p));
    chk({tag, "_busy"}, 16'(bus.in_ready), 16'd0);
  endtask

  // Complete the output handshake and confirm the return to IDLE.
  task automatic release_result(input logic [7:0] exp_p, input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 16'(bus.out_valid), 16'd0);
    chk({tag, "_ready_rise"}, 16'(bus.in_ready), 16'd1);
    chk({tag, "_held"}, 16'(bus.product), 16'(exp_p));
  endtask

  initial begin
    int         ia, ib;
    logic [7:0] ep;
    logic [3:0] av, bv;
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.A           = '0;
    bus.B           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_product", 16'(bus.product), 16'd0);

    issue_and_wait(4'd15, 4'd15, 1'b0, 8'hE1, 5, "u15x15");
    release_result(8'hE1, "u15x15");

`ifdef MULT_EARLY_TERM_EN
    issue_and_wait(4'h8, 4'h8, 1'b1, 8'h40, 5, "sm8xm8");
    release_result(8'h40, "sm8xm8");
    issue_and_wait(4'hD, 4'h5, 1'b1, 8'hF1, 4, "sm3x5");
    release_result(8'hF1, "sm3x5");
    issue_and_wait(4'h7, 4'h8, 1'b1, 8'hC8, 5, "s7xm8");
    release_result(8'hC8, "s7xm8");
    issue_and_wait(4'd9, 4'd1, 1'b0, 8'h09, 2, "early9x1");
    release_result(8'h09, "early9x1");
`else
    issue_and_wait(4'h8, 4'h8, 1'b1, 8'h40, 5, "sm8xm8");
    release_result(8'h40, "sm8xm8");
    issue_and_wait(4'hD, 4'h5, 1'b1, 8'hF1, 5, "sm3x5");
    release_result(8'hF1, "sm3x5");
    issue_and_wait(4'h7, 4'h8, 1'b1, 8'hC8, 5, "s7xm8");
    release_result(8'hC8, "s7xm8");
    issue_and_wait(4'd9, 4'd1, 1'b0, 8'h09, 5, "early9x1");
    release_result(8'h09, "early9x1");
`endif

    // Backpressure: result held, new operands ignored while out_ready is low.
    issue_and_wait(4'd15, 4'd15, 1'b0, 8'hE1, 5, "bp");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = 4'd1;
      bus.B        = 4'd1;
      @(posedge clk); #1;
      chk("bp_product", 16'(bus.product), 16'hE1);
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
      chk("bp_out_valid", 16'(bus.out_valid), 16'd1);
    end
    bus.in_valid = 1'b0;
    release_result(8'hE1, "bp");
    issue_and_wait(4'd2, 4'd3, 1'b0, 8'h06, lat_for(4'd3, 1'b0), "after_bp");
    release_result(8'h06, "after_bp");

    // Reset sampled at t0+2 discards the partial result.
    bus.in_valid    = 1'b1;
    bus.A           = 4'd5;
    bus.B           = 4'd13;
    bus.signed_mode = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("midrst_product", 16'(bus.product), 16'd0);
    chk("midrst_in_ready", 16'(bus.in_ready), 16'd1);
    issue_and_wait(4'd3, 4'd3, 1'b0, 8'h09, lat_for(4'd3, 1'b0), "post_rst3x3");
    release_result(8'h09, "post_rst3x3");

    // Full sweep in both modes against integer multiplication.
    for (int sm = 0; sm < 2; sm++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          av = 4'(a);
          bv = 4'(b);
          ia = (sm == 1) ? int'($signed(av)) : a;
          ib = (sm == 1) ? int'($signed(bv)) : b;
          ep = 8'(ia * ib);
          bus.out_ready = 1'b0;
          issue_and_wait(av, bv, 1'(sm), ep, lat_for(bv, 1'(sm)), "sweep");
          release_result(ep, "sweep");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
